sync_frame_receiver: RTL
========================

Name: sync_frame_receiver

Overview:
- Serial frame receiver that wraps a sync-word detector and uses it to sequence a payload-capture datapath.
- Hunts the 1-bit input stream for a programmable sync pattern (default "110011"), then shifts in a fixed-length payload and presents it on a valid/ready output port.
- Sits between a bit-serial source and a word-oriented consumer; it is the controller that decides when the detector is active and when its hits are honoured.

Parameters:
- SYNC_W, 6, sync pattern length in bits (2..16).
- SYNC_PATTERN, 6'b110011, pattern to match; MSB is the first bit received.
- PAYLOAD_W, 8, payload bits per frame (1..32).
- CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  receiver enable; low = flush and hold in HUNT.
- bit_valid  in  1  qualifies a; bits are consumed only when high.
- a  in  1  serial data bit.
- data  out  PAYLOAD_W  received payload; first payload bit lands in the MSB.
- data_valid  out  1  data holds an unconsumed word.
- data_ready  in  1  consumer accepts data when data_valid && data_ready.
- in_frame  out  1  high while in PAYLOAD state.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- frame_count  out  CNT_W  count of frames loaded into data; wraps.

Behaviour:
- Reset values: state=HUNT, sync shift register=0, payload shift register=0, bit counter=0, data=0, data_valid=0, overrun=0, frame_count=0.
- States:
  - HUNT: every accepted bit (bit_valid=1) shifts into the SYNC_W-bit history.
  - Match condition: {history[SYNC_W-2:0], a} == SYNC_PATTERN on an accepted bit.
  - On match: next state is PAYLOAD, bit counter cleared, history cleared.
  - Overlapping prefixes are matched, e.g. "11110011" hits on its final bit.
  - Fewer than SYNC_W bits received since entering HUNT: the cleared history still participates in the comparison. This matters only for patterns with leading zeros, and the behaviour is intended.
  - PAYLOAD: each accepted bit shifts into the payload register MSB-first and increments the bit counter.
  - On the PAYLOAD_W-th accepted bit: next state is HUNT and history is cleared. Payload bits never contribute to sync detection.
- Output load, evaluated on the cycle the last payload bit is accepted:
  - If data_valid=0, or data_valid && data_ready: data <= {payload[PAYLOAD_W-2:0], a}, data_valid <= 1, frame_count += 1 (mod 2^CNT_W). data_valid stays high, with no gap, when a handshake and a load coincide.
  - Else (stalled): new word is dropped, data and frame_count are unchanged, overrun=1 for exactly the next cycle.
- Handshake:
  - data_valid && data_ready with no load in the same cycle: data_valid <= 0 next cycle.
  - data is stable while data_valid && !data_ready.
- Latency: data_valid rises 1 cycle after the clock edge that accepts the last payload bit.
- bit_valid=0: no state, history or counter change. Gaps of any length are permitted anywhere in a frame.
- en=0:
  - Next state is HUNT; history, payload register and bit counter are cleared.
  - A partial frame is discarded with no overrun.
  - The output register and handshake keep operating, so a pending word can still drain.
- rst mid-frame or mid-handshake: everything returns to reset values on the next edge. A pending word is lost.
- in_frame = (state == PAYLOAD), decoded from state only.

Decomposition:
- Package sync_rx_pkg:
  - state enum {HUNT, PAYLOAD}, logic[0:0].
  - Default SYNC_PATTERN/SYNC_W constants.
- Sub-module sync_word_matcher:
  - Holds the SYNC_W history register.
  - Inputs: clk, rst, clr, shift_en, a. Output: combinational match.
- Top level holds the FSM, payload shifter, bit counter, output register/handshake and frame counter.

Test Plan:
- Sync + payload, data_ready=1: after reset, bits 110011 then 10100101, one per cycle -> data=8'hA5, data_valid=1 for exactly 1 cycle, starting 1 cycle after the last bit; frame_count=1; in_frame high for exactly 8 accepted bits.
- Overlapping prefix and payload immunity: stream 11110011 then 11001100 then 110011 then 00001111 -> exactly 2 words, 8'hCC then 8'h0F; the "110011" inside the first payload is not a sync; frame_count=2.
- Backpressure and overrun: data_ready=0, two back-to-back frames with payloads 8'h3C and 8'hC3 -> data stays 8'h3C; overrun pulses for 1 cycle after the second frame; frame_count=1. Raise data_ready -> data_valid falls next cycle.
- Simultaneous handshake and load: data_ready=1 exactly on the cycle the second frame (8'h81) completes while 8'h3C is pending -> data becomes 8'h81 with no data_valid gap; no overrun; frame_count=2.
- Gaps and enable abort: bit_valid toggled 1/0 through a frame with payload 8'h5A -> data=8'h5A. Next frame: drop en for 1 cycle after 4 payload bits, then resume the old bits -> no output; a fresh sync plus 8'h11 -> 8'h11.
- Reset mid-payload: assert rst after 3 payload bits with 8'h77 pending unconsumed -> next cycle data_valid=0, data=0, frame_count=0, in_frame=0; the following sync plus 8'hE7 -> data=8'hE7.

Source files
------------

// File: rtl/sync_rx_pkg.sv
// Shared types and defaults for the sync frame receiver.
// Provides the FSM state enum and the default sync word constants.
package sync_rx_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam int               SYNC_W_DEF       = 6;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PATTERN_DEF = 6'b110011;

endpackage

// File: rtl/sync_word_matcher.sv
// Sync word history register with combinational pattern compare.
// Ports: clk, rst (sync, high), clr (history clear), shift_en,
//        a (serial bit), match (candidate history equals pattern).
module sync_word_matcher
    import sync_rx_pkg::*;
#(
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic a,
    output logic match
);

    logic [SYNC_W-1:0] r_hist;
    logic [SYNC_W-1:0] w_cand;

    // Candidate includes the bit being presented this cycle.
    assign w_cand = {r_hist[SYNC_W-2:0], a};
    assign match  = (w_cand == SYNC_PATTERN);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_hist <= '0;
        end else if (shift_en) begin
            r_hist <= w_cand;
        end
    end

endmodule

// File: rtl/sync_frame_receiver.sv
// Serial frame receiver: hunts for a sync word, then captures a payload.
// Ports: clk, rst, en, bit_valid, a in; data/data_valid/data_ready
//        handshake; in_frame, overrun pulse, frame_count out.
module sync_frame_receiver
    import sync_rx_pkg::*;
#(
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int                PAYLOAD_W    = 8,
    parameter int                CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 bit_valid,
    input  logic                 a,
    output logic [PAYLOAD_W-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 in_frame,
    output logic                 overrun,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int BCNT_W = $clog2(PAYLOAD_W + 1);
    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(PAYLOAD_W - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [PAYLOAD_W-1:0] r_pay;
    logic [BCNT_W-1:0]    r_bcnt;
    logic [PAYLOAD_W-1:0] r_data;
    logic                 r_valid;
    logic                 r_ovr;
    logic [CNT_W-1:0]     r_fc;

    logic                 w_acc;
    logic                 w_hunt_acc;
    logic                 w_pay_acc;
    logic                 w_match;
    logic                 w_hit;
    logic                 w_last;
    logic                 w_can_load;
    logic [PAYLOAD_W:0]   w_shift;

    assign w_acc      = en && bit_valid;
    assign w_hunt_acc = w_acc && (r_state == HUNT);
    assign w_pay_acc  = w_acc && (r_state == PAYLOAD);
    assign w_hit      = w_hunt_acc && w_match;
    assign w_last     = w_pay_acc && (r_bcnt == LAST_IDX);
    assign w_can_load = !r_valid || data_ready;

    // Low PAYLOAD_W bits are {payload[W-2:0], a}; works for W=1 too.
    assign w_shift = {r_pay, a};

    sync_word_matcher #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .clr      (!en || w_hit || w_last),
        .shift_en (w_hunt_acc),
        .a        (a),
        .match    (w_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT:    if (w_hit)  w_state_nxt = PAYLOAD;
            PAYLOAD: if (w_last) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
        if (!en) begin
            w_state_nxt = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_pay  <= '0;
            r_bcnt <= '0;
        end else if (w_hit) begin
            r_bcnt <= '0;
        end else if (w_pay_acc) begin
            r_pay  <= w_shift[PAYLOAD_W-1:0];
            r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
        end
    end

    // Output register keeps running with en low so a word can drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_fc    <= '0;
        end else begin
            r_ovr <= w_last && !w_can_load;
            if (w_last && w_can_load) begin
                r_data  <= w_shift[PAYLOAD_W-1:0];
                r_valid <= 1'b1;
                r_fc    <= r_fc + 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign data_valid  = r_valid;
    assign overrun     = r_ovr;
    assign frame_count = r_fc;
    assign in_frame    = (r_state == PAYLOAD);

endmodule
